// File: rtl/viterbi_traceback.sv
// viterbi_traceback: stores per-step backpointers, picks the best final state and
// streams the decoded path backwards over a valid/ready handshake.
module viterbi_traceback #(
    parameter int I = 3,
    parameter int W = 20,
    parameter int T_MAX = 16,
    localparam int S = $clog2(I),
    localparam int C = $clog2(T_MAX + 1),
    localparam int P = $clog2(T_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psi_valid,
    input  logic [S*I-1:0]        psi_in_flat,
    input  logic                  psi_last,
    input  logic signed [W*I-1:0] delta_final_flat,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [S-1:0]          out_state,
    output logic [C-1:0]          out_step,
    output logic                  out_last,
    output logic [1:0]            err
);
    localparam logic [1:0] COLLECT = 2'd0, SELECT = 2'd1, TRACE = 2'd2;
    logic [1:0] state;
    logic [P-1:0] wr_ptr;
    logic [C-1:0] t;
    logic [S-1:0] cur_state, best, p_raw;
    logic signed [W-1:0] best_val;
    logic [W*I-1:0] delta_q;
    logic [S*I-1:0] psi_mem [T_MAX];
    logic [S*I-1:0] rd_vec;
    logic accept, at_end, bad_p;
    assign in_ready  = state == COLLECT;
    assign out_valid = state == TRACE;
    assign out_state = cur_state;
    assign out_step  = t;
    assign out_last  = out_valid && t == '0;
    assign accept    = psi_valid && in_ready;
    assign at_end    = wr_ptr == P'(T_MAX - 1);
    assign rd_vec    = psi_mem[P'(t - 1'b1)];
    assign p_raw     = rd_vec[int'(cur_state)*S +: S];
    assign bad_p     = int'(p_raw) >= I;
    // strict > scanning upward keeps the lowest index on ties
    always_comb begin
        best = '0;
        best_val = delta_q[W-1:0];
        for (int j = 1; j < I; j++)
            if ($signed(delta_q[W*j +: W]) > best_val) begin
                best = S'(j);
                best_val = delta_q[W*j +: W];
            end
    end
    always_ff @(posedge clk)
        if (accept) psi_mem[wr_ptr] <= psi_in_flat;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            wr_ptr    <= '0;
            t         <= '0;
            cur_state <= '0;
            delta_q   <= '0;
            err       <= '0;
        end else begin
            case (state)
                COLLECT: if (accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (psi_last || at_end) begin
                        delta_q <= delta_final_flat;
                        t       <= C'(wr_ptr) + 1'b1;
                        state   <= SELECT;
                        if (!psi_last) err[0] <= 1'b1;
                    end
                end
                SELECT: begin
                    cur_state <= best;
                    state     <= TRACE;
                end
                TRACE: if (out_ready) begin
                    if (t != '0) begin
                        cur_state <= bad_p ? '0 : p_raw;
                        t         <= t - 1'b1;
                        if (bad_p) err[1] <= 1'b1;
                    end else begin
                        wr_ptr <= '0;
                        state  <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: directed vectors, expected path beats queued by stimulus
// and checked by an independent output monitor.
module tb_viterbi_traceback;
    logic clk = 0, rst = 1, psi_valid = 0, psi_last = 0, out_ready = 1;
    logic [5:0] psi_in_flat = '0;
    logic signed [59:0] delta_final_flat = '0;
    logic in_ready, out_valid, out_last;
    logic [1:0] out_state, err;
    logic [4:0] out_step;
    int total = 0, bad = 0;
    logic [7:0] q[$];
    logic [5:0] psi_q[$];
    logic [7:0] ps;
    bit stall = 0;

    viterbi_traceback dut (
        .clk(clk), .rst(rst), .psi_valid(psi_valid), .psi_in_flat(psi_in_flat),
        .psi_last(psi_last), .delta_final_flat(delta_final_flat), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_step(out_step), .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [5:0] pk(input logic [1:0] a, b, c);
        return {c, b, a};
    endfunction

    function automatic logic [59:0] dk(input int a, b, c);
        return {c[19:0], b[19:0], a[19:0]};
    endfunction

    task automatic ex(input int s, input int step, input bit last);
        q.push_back({s[1:0], step[4:0], last});
    endtask

    task automatic send(input logic [5:0] p, input logic [59:0] d, input bit last);
        psi_valid = 1; psi_in_flat = p; delta_final_flat = d; psi_last = last;
        @(posedge clk); #1;
        psi_valid = 0; psi_last = 0;
    endtask

    task automatic run_seq(input logic [59:0] d, input bit use_last);
        for (int n = 0; n < psi_q.size(); n++) send(psi_q[n], d, use_last && n == psi_q.size() - 1);
        chk("select_idle", {out_valid, in_ready}, 2'b00);
        @(posedge clk); #1;
        chk("trace_valid", out_valid, 1);
    endtask

    task automatic drain(input bit rnd);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            if (q.size() == 0) begin
                done = 1; psi_valid = 0; psi_last = 0; out_ready = 1;
            end else if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                psi_valid = 1'($urandom_range(0, 1));
                psi_last = 1'($urandom_range(0, 1));
                psi_in_flat = 6'($urandom);
            end
        end
        if (!done) chk("drain_timeout", q.size(), 0);
        chk("ready_back", in_ready, 1);
    endtask

    task automatic pulse_rst();
        rst = 1; @(posedge clk); #1; rst = 0;
    endtask

    always @(negedge clk) begin
        if (rst) stall <= 0;
        else begin
            if (out_valid) chk("in_ready_low", in_ready, 0);
            if (stall) chk("hold", {out_state, out_step, out_last}, ps);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", {out_state, out_step, out_last}, 8'hff);
                else chk("out", {out_state, out_step, out_last}, q.pop_front());
            end
            stall <= out_valid && !out_ready;
            ps <= {out_state, out_step, out_last};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1; rst = 0;
        chk("rst_vals", {in_ready, out_valid, out_state, out_step, out_last, err}, {2'b10, 2'b0, 5'b0, 1'b0, 2'b0});
        // basic decode
        psi_q = '{pk(1, 2, 0)};
        ex(1, 1, 0); ex(2, 0, 1);
        run_seq(dk(-5, 10, 3), 1);
        drain(0);
        chk("basic_err", err, 0);
        // tie-break
        psi_q = '{pk(1, 1, 1)};
        ex(0, 1, 0); ex(1, 0, 1);
        run_seq(dk(7, 7, 7), 1);
        drain(0);
        // backpressure with psi_valid noise during trace
        psi_q = '{pk(2, 0, 1), pk(1, 2, 0), pk(0, 0, 2), pk(2, 2, 1)};
        ex(1, 4, 0); ex(2, 3, 0); ex(2, 2, 0); ex(0, 1, 0); ex(2, 0, 1);
        run_seq(dk(-100, -3, -50), 1);
        drain(1);
        chk("bp_err", err, 0);
        // overflow: 16 beats without psi_last
        psi_q.delete();
        for (int n = 0; n < 16; n++) psi_q.push_back(pk(1, 2, 0));
        for (int n = 16; n >= 0; n--) ex((18 - n) % 3, n, n == 0);
        run_seq(dk(1, 2, 3), 0);
        chk("ovf_err_set", err, 2'b01);
        drain(0);
        chk("ovf_err_hold", err, 2'b01);
        pulse_rst();
        chk("ovf_err_clr", err, 0);
        // legal last on beat 16
        for (int n = 16; n >= 0; n--) ex((16 - n) % 3, n, n == 0);
        run_seq(dk(3, 2, 1), 1);
        drain(0);
        chk("legal16_err", err, 0);
        // out-of-range backpointer
        psi_q = '{pk(2, 0, 0), pk(3, 1, 1)};
        ex(0, 2, 0); ex(0, 1, 0); ex(2, 0, 1);
        run_seq(dk(9, 0, 0), 1);
        drain(0);
        chk("badp_err", err, 2'b10);
        psi_q = '{pk(1, 2, 0)};
        ex(1, 1, 0); ex(2, 0, 1);
        run_seq(dk(-5, 10, 3), 1);
        drain(0);
        chk("badp_sticky", err, 2'b10);
        // reset mid-trace
        out_ready = 0;
        psi_q = '{pk(2, 0, 1), pk(1, 2, 0), pk(0, 0, 2), pk(2, 2, 1)};
        run_seq(dk(-100, -3, -50), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_step", {out_valid, out_step}, {1'b1, 5'd4});
        pulse_rst();
        out_ready = 1;
        chk("midrst", {out_valid, in_ready, err}, {2'b01, 2'b00});
        psi_q = '{pk(1, 2, 0)};
        ex(1, 1, 0); ex(2, 0, 1);
        run_seq(dk(-5, 10, 3), 1);
        drain(0);
        chk("post_rst_err", err, 0);
        chk("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
